// File: rtl/ram_pkg.sv
// Shared types and sizing helpers for the ram_sync_clr memory block.
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  function automatic int nlanes(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  // Bits needed to index v entries; at least 1 so a single-word RAM still has a pointer.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// One-cycle pulse on each rising edge of d; used for button-driven strobes.
module edge_rise (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q_pulse
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign q_pulse = d & ~d_q;

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port synchronous RAM with byte-lane writes, registered read and a hardware clear engine.
//   state    | meaning
//   ST_CLEAR | zeroing mem[clr_ptr] each cycle, accesses ignored, busy=1
//   ST_IDLE  | normal read/write, clr_req starts a new clear
module ram_sync_clr
  import ram_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LANE_W  = 8,
  parameter bit WE_EDGE = 1'b1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic [ADDR_W-1:0]                     addr,
  input  logic [DATA_W-1:0]                     din,
  input  logic                                  we,
  input  logic [nlanes(DATA_W, LANE_W)-1:0]     be,
  input  logic                                  clr_req,
  output logic [DATA_W-1:0]                     dout,
  output logic                                  dout_valid,
  output logic                                  err,
  output logic                                  busy
);

  localparam int NLANES = nlanes(DATA_W, LANE_W);
  localparam int PTR_W  = clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  logic [PTR_W-1:0]  clr_ptr;
  logic              wr;
  logic              in_range;
  logic              wr_idle;
  logic [DATA_W-1:0] old_word;
  logic [DATA_W-1:0] merged;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // A rising edge that lands while busy is consumed by edge_rise, not queued.
  generate
    if (WE_EDGE) begin : g_edge
      edge_rise u_we_edge (
        .clk     (clk),
        .reset   (reset),
        .d       (we),
        .q_pulse (wr)
      );
    end else begin : g_level
      assign wr = we;
    end
  endgenerate

  assign busy     = (state == ST_CLEAR);
  assign in_range = ({1'b0, addr} < (ADDR_W + 1)'(DEPTH));
  assign old_word = mem[addr];
  assign wr_idle  = !busy && wr && in_range && !clr_req;

  always_comb begin
    merged = old_word;
    for (int i = 0; i < NLANES; i++) begin
      if (be[i]) merged[i*LANE_W +: LANE_W] = din[i*LANE_W +: LANE_W];
    end
  end

  // Reset blocks the array write so an in-flight write never lands.
  always_comb begin
    mem_we    = !reset && (busy || wr_idle);
    mem_addr  = busy ? ADDR_W'(clr_ptr) : addr;
    mem_wdata = busy ? '0 : merged;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CLEAR;
      clr_ptr    <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          dout       <= '0;
          dout_valid <= 1'b0;
          err        <= 1'b0;
          if (clr_ptr == PTR_W'(DEPTH - 1)) begin
            state   <= ST_IDLE;
            clr_ptr <= '0;
          end else begin
            clr_ptr <= clr_ptr + 1'b1;
          end
        end
        default: begin
          if (clr_req) begin
            state      <= ST_CLEAR;
            clr_ptr    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
          end else if (in_range) begin
            dout       <= wr ? merged : old_word;
            dout_valid <= 1'b1;
            err        <= 1'b0;
          end else begin
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr: edge-write instance plus a level-write instance for the held-we case.
module tb_ram_sync_clr;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;
  localparam int LANE_W = 8;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] din;
  logic              we;
  logic [1:0]        be;
  logic              clr_req;

  logic [DATA_W-1:0] dout_e, dout_l;
  logic              valid_e, valid_l, err_e, err_l, busy_e, busy_l;

  int n_checks;
  int n_fail;

  ram_sync_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANE_W(LANE_W), .WE_EDGE(1'b1)) dut_e (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .be(be), .clr_req(clr_req),
    .dout(dout_e), .dout_valid(valid_e), .err(err_e), .busy(busy_e)
  );

  ram_sync_clr #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .LANE_W(LANE_W), .WE_EDGE(1'b0)) dut_l (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .we(we), .be(be), .clr_req(clr_req),
    .dout(dout_l), .dout_valid(valid_l), .err(err_l), .busy(busy_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges spent busy, bounded so a stuck clear still reaches the summary.
  task automatic wait_idle(output int n);
    n = 0;
    while (busy_e && n < 1000) begin
      tick();
      n++;
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [15:0] d, input logic [1:0] b);
    addr = a; din = d; be = b; we = 1'b1;
    tick();
    we = 1'b0;
    tick();
  endtask

  int n;
  int bad;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset = 1'b1; addr = '0; din = '0; we = 1'b0; be = '0; clr_req = 1'b0;
    tick();
    reset = 1'b0;
    chk("rst_busy", 32'(busy_e), 32'd1);
    chk("rst_dout", 32'(dout_e), 32'h0);
    chk("rst_valid", 32'(valid_e), 32'd0);
    chk("rst_err", 32'(err_e), 32'd0);

    wait_idle(n);
    chk("clear_len", 32'(n), 32'd200);
    chk("clear_len_level", 32'(busy_l), 32'd0);

    addr = 8'h05;
    tick();
    chk("rd05_dout", 32'(dout_e), 32'h0000);
    chk("rd05_valid", 32'(valid_e), 32'd1);

    // we held for 10 cycles, data changes mid-hold
    addr = 8'h10; din = 16'hBEEF; be = 2'b11; we = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) din = 16'h1234;
      tick();
    end
    we = 1'b0;
    tick();
    tick();
    chk("held_edge", 32'(dout_e), 32'hBEEF);
    chk("held_level", 32'(dout_l), 32'h1234);

    write_word(8'h10, 16'h00AA, 2'b01);
    chk("lane_lo", 32'(dout_e), 32'hBEAA);
    write_word(8'h10, 16'h1111, 2'b00);
    chk("lane_none", 32'(dout_e), 32'hBEAA);

    write_word(8'h48, 16'h4848, 2'b11);
    addr = 8'hC8; din = 16'hFFFF; be = 2'b11; we = 1'b1;
    tick();
    we = 1'b0;
    chk("oor_err", 32'(err_e), 32'd1);
    chk("oor_valid", 32'(valid_e), 32'd0);
    chk("oor_dout", 32'(dout_e), 32'h0);
    addr = 8'h48;
    tick();
    chk("no_alias", 32'(dout_e), 32'h4848);
    chk("no_alias_err", 32'(err_e), 32'd0);

    addr = 8'h20; din = 16'h5A5A; be = 2'b11; we = 1'b1;
    tick();
    we = 1'b0;
    chk("wfirst_dout", 32'(dout_e), 32'h5A5A);
    chk("wfirst_valid", 32'(valid_e), 32'd1);

    // reset partway through a clear restarts the full sweep
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    chk("midclr_busy", 32'(busy_e), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_idle(n);
    chk("midclr_len", 32'(n), 32'd200);
    addr = 8'h10;
    tick();
    chk("midclr_zeroed", 32'(dout_e), 32'h0);

    write_word(8'h30, 16'h7777, 2'b11);
    addr = 8'h30;
    tick();
    chk("pre_clr_30", 32'(dout_e), 32'h7777);

    addr = 8'h31; din = 16'h9999; be = 2'b11; we = 1'b1; clr_req = 1'b1;
    tick();
    clr_req = 1'b0; we = 1'b0;
    chk("clrreq_busy", 32'(busy_e), 32'd1);
    wait_idle(n);
    chk("clrreq_len", 32'(n), 32'd200);

    bad = 0;
    for (int a = 0; a < DEPTH; a++) begin
      addr = 8'(a);
      tick();
      if (dout_e !== 16'h0 || valid_e !== 1'b1) bad++;
      if (a == 8'h30) chk("post_clr_30", 32'(dout_e), 32'h0);
      if (a == 8'h31) chk("dropped_wr_31", 32'(dout_e), 32'h0);
    end
    chk("post_clr_nonzero", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_sync_clr.md
Name: ram_sync_clr

Overview:
Parametrised synchronous single-port RAM. It is the next-generation replacement for the fixed 256x16 lab memory. It adds configurable width and depth, byte-lane write enables, a rising-edge write mode so a debounced button can drive we directly, and a hardware clear engine. It also provides a registered read with a valid/error flag, and sits between the front-panel input logic and the memory display / CPU datapath.

Parameters:
DATA_W, 16, data word width in bits; must be a multiple of LANE_W
ADDR_W, 8, address width in bits
DEPTH, 256, number of implemented words; 1 <= DEPTH <= 2**ADDR_W
LANE_W, 8, bits per byte-enable lane; NLANES = DATA_W/LANE_W
WE_EDGE, 1, 1 = write on rising edge of we only; 0 = write on every cycle we is high

Ports:
clk  input  1  system clock (100 MHz board clock)
reset  input  1  synchronous, active-high reset
addr  input  ADDR_W  read/write word address
din  input  DATA_W  write data
we  input  1  write enable (level or button-derived; see WE_EDGE)
be  input  NLANES  byte-lane enables; bit i gates din[i*LANE_W +: LANE_W]
clr_req  input  1  single-cycle request to zero the whole array
dout  output  DATA_W  registered read data
dout_valid  output  1  dout holds a valid in-range read
err  output  1  addr >= DEPTH on the previous IDLE cycle
busy  output  1  clear engine running; all accesses ignored

Behaviour:
- One clock (clk); reset is synchronous and active-high. Everything updates on the rising edge of clk.
- Reset values: dout=0, dout_valid=0, err=0, busy=1, state=CLEAR, clr_ptr=0, we_q=0.
- The memory array itself is not reset directly; it is zeroed by the CLEAR state.
- FSM has two states, CLEAR and IDLE.
- CLEAR state:
  - Writes 0 to mem[clr_ptr] and increments clr_ptr each cycle.
  - When clr_ptr == DEPTH-1, the next state is IDLE.
  - busy is high for exactly DEPTH cycles after reset deasserts.
  - we, be, din, addr and clr_req are ignored. dout=0, dout_valid=0, err=0.
- IDLE state:
  - clr_req=1 moves to CLEAR with clr_ptr=0 on the next edge. Any write presented in that same cycle is dropped.
  - Reads are always active. Registered dout has one-cycle latency. dout_valid=1 and err=0 when addr < DEPTH.
  - When addr >= DEPTH: dout=0, dout_valid=0, err=1 for that one cycle. Any write is discarded and no aliasing occurs.
- Write strobe:
  - WE_EDGE=1: wr = we & ~we_q. we_q samples we every cycle, including during CLEAR, so a rising edge that occurs while busy is lost, not queued. Holding we high produces exactly one write.
  - WE_EDGE=0: wr = we.
- Write merge: for each lane i with be[i]=1, mem[addr] lane i takes din lane i. Lanes with be[i]=0 are unchanged. be=0 with wr=1 is a legal no-op.
- Read-during-write to the same address is write-first: dout on the next cycle equals the merged new word.
- Reset mid-CLEAR restarts the clear from clr_ptr=0, giving a full DEPTH cycles of busy.
- Reset mid-write: reset has priority and the write does not occur.
- clr_ptr is sized to hold DEPTH-1; it never wraps past DEPTH.

Decomposition:
- Package ram_pkg:
  - state enum {ST_CLEAR, ST_IDLE}
  - NLANES derivation
  - clog2 helper for clr_ptr width
- One sub-module: edge_rise (clk, reset, d, q_pulse), instantiated only when WE_EDGE=1. It is reusable for other button-driven strobes.
- The array is inferred as block RAM in the top module.

Test Plan (DATA_W=16, ADDR_W=8, DEPTH=200, LANE_W=8, WE_EDGE=1 unless noted):
- Clear after reset: reset high 1 cycle -> busy=1 for exactly 200 cycles then 0. Then read addr 0x05 -> dout=0x0000, dout_valid=1 one cycle later.
- Held write: we held 10 cycles, addr=0x10, din=0xBEEF, be=2'b11; din changes to 0x1234 on cycle 3 -> read 0x10 = 0xBEEF (single write only). With WE_EDGE=0, the same stimulus -> 0x1234.
- Byte-lane write: be=2'b01, din=0x00AA at 0x10 after the previous write -> read 0x10 = 0xBEAA. be=2'b00 -> value unchanged.
- Out of range: write addr 0xC8 (200), din=0xFFFF -> err=1, dout_valid=0, dout=0 next cycle. Read 0x48 afterwards shows its prior value (no alias).
- Write-first: write addr 0x20, din=0x5A5A, be=11, previous content 0x0000 -> dout=0x5A5A on the following cycle.
- Clear control: assert reset at clear cycle 50 -> busy stays high 200 more cycles. Later, in IDLE after writes, a clr_req pulse with we rising the same cycle -> busy for 200 cycles, then every address 0..199 reads 0x0000 and the concurrent write is absent.
